// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs symbolic MIPS instruction requests into 32-bit words, tags each
//   word with a sequential word address and streams the (address, word)
//   pairs into an instruction memory write port through a small FIFO.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start, base_addr  load the write-address counter, clear err/count (idle only)
//   req_valid/ready   request handshake; req_kind selects the instruction
//   req_rs/rt/rd      register fields
//   req_imm           immediate for LW, SW, ADDI, LUI, ORI
//   req_target        J target; for BEQ, [15:0] is the absolute destination
//   mem_we/addr/wdata instruction-memory write port (zeroed when idle)
//   mem_ready         memory accepts the write this cycle
//   err               sticky illegal-kind flag
//   count             words written, saturating
//   idle              FIFO empty
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic              idle
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [3:0] K_ADD  = 4'd0;
  localparam logic [3:0] K_SUB  = 4'd1;
  localparam logic [3:0] K_AND  = 4'd2;
  localparam logic [3:0] K_OR   = 4'd3;
  localparam logic [3:0] K_SLT  = 4'd4;
  localparam logic [3:0] K_LW   = 4'd5;
  localparam logic [3:0] K_SW   = 4'd6;
  localparam logic [3:0] K_BEQ  = 4'd7;
  localparam logic [3:0] K_ADDI = 4'd8;
  localparam logic [3:0] K_LUI  = 4'd9;
  localparam logic [3:0] K_ORI  = 4'd10;
  localparam logic [3:0] K_J    = 4'd11;

  localparam logic [PW:0]       PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [31:0]       fifo_word [DEPTH];
  logic [ADDR_W-1:0] wr_addr;

  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        legal;
  logic [31:0] word;
  logic [15:0] offset;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign idle   = empty;

  // start masks ready so an accepted request never races a counter reload.
  assign req_ready = ~full & ~start;
  assign accept    = req_valid & req_ready;
  assign push      = accept & legal;
  assign pop       = ~empty & mem_ready;

  // BEQ offset is relative to the word after the branch, taken mod 2^16.
  assign offset = req_target[15:0] - ({{(16-ADDR_W){1'b0}}, wr_addr} + 16'd1);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (req_kind)
      K_ADD:   word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
      K_SUB:   word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010};
      K_AND:   word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100100};
      K_OR:    word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100101};
      K_SLT:   word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b101010};
      K_LW:    word = {6'b100011, req_rs, req_rt, req_imm};
      K_SW:    word = {6'b101011, req_rs, req_rt, req_imm};
      K_BEQ:   word = {6'b000100, req_rs, req_rt, offset};
      K_ADDI:  word = {6'b001000, req_rs, req_rt, req_imm};
      K_LUI:   word = {6'b001111, 5'b00000, req_rt, req_imm};
      K_ORI:   word = {6'b001101, req_rs, req_rt, req_imm};
      K_J:     word = {6'b000010, req_target};
      default: legal = 1'b0;
    endcase
  end

  // FIFO storage needs no reset: the output mux zeroes it while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= wr_addr;
      fifo_word[wr_ptr[PW-1:0]] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_addr <= '0;
      err     <= 1'b0;
      count   <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        wr_addr <= wr_addr + ADDR_ONE;
      end
      if (accept && !legal) begin
        err <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (count != '1) begin
          count <= count + CNT_ONE;
        end
      end
      // Honoured only while empty, so no pop or push can coincide.
      if (start && empty) begin
        wr_addr <= base_addr;
        err     <= 1'b0;
        count   <= '0;
      end
    end
  end

  assign mem_we    = ~empty;
  assign mem_addr  = empty ? '0 : fifo_addr[rd_ptr[PW-1:0]];
  assign mem_wdata = empty ? '0 : fifo_word[rd_ptr[PW-1:0]];

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed bench for instr_encoder. A queue-based reference model tracks
//   the expected FIFO contents, write address, err and count; one compare
//   process checks every DUT output against it each cycle. Literal
//   expectations for each scenario pin the model to hand-encoded words.
module tb_instr_encoder;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_kind;
  logic [4:0]        req_rs, req_rt, req_rd;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              err;
  logic [ADDR_W:0]   count;
  logic              idle;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_target(req_target), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .err(err),
    .count(count), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit encode(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [15:0] imm,
                                input logic [25:0] tgt, input int a, output logic [31:0] w);
    int op;
    int fn;
    int off;
    w = 32'h0;
    if (k <= 4) begin
      fn = (k == 0) ? 32 : (k == 1) ? 34 : (k == 2) ? 36 : (k == 3) ? 37 : 42;
      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
      return 1'b1;
    end
    case (k)
      5:  op = 35;
      6:  op = 43;
      8:  op = 8;
      9:  op = 15;
      10: op = 13;
      7: begin
        off = (int'(tgt[15:0]) - (a + 1)) & 32'hFFFF;
        w = (32'd4 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(off);
        return 1'b1;
      end
      11: begin
        w = (32'd2 << 26) | 32'(tgt);
        return 1'b1;
      end
      default: return 1'b0;
    endcase
    w = (32'(op) << 26) | ((k == 9) ? 32'h0 : (32'(rs) << 21)) | (32'(rt) << 16) | 32'(imm);
    return 1'b1;
  endfunction

  int          q_addr[$];
  logic [31:0] q_data[$];
  int          m_wr;
  bit          m_err;
  int          m_count;

  always @(posedge clk or negedge rst_n) begin
    bit          acc;
    bit          ok;
    logic [31:0] w;
    if (!rst_n) begin
      q_addr.delete();
      q_data.delete();
      m_wr    = 0;
      m_err   = 1'b0;
      m_count = 0;
    end else begin
      acc = req_valid && (q_addr.size() < DEPTH) && !start;
      if (start && q_addr.size() == 0) begin
        m_wr    = int'(base_addr);
        m_err   = 1'b0;
        m_count = 0;
      end
      if (q_addr.size() > 0 && mem_ready) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        if (m_count < (1 << (ADDR_W + 1)) - 1) m_count++;
      end
      if (acc) begin
        ok = encode(req_kind, req_rs, req_rt, req_rd, req_imm, req_target, m_wr, w);
        if (ok) begin
          q_addr.push_back(m_wr);
          q_data.push_back(w);
          m_wr = (m_wr + 1) % (1 << ADDR_W);
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  // Observed writes, for the literal per-scenario expectations.
  int          lg_addr[$];
  logic [31:0] lg_data[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("mem_we", 32'(mem_we), 32'(q_addr.size() > 0));
      if (q_addr.size() > 0) begin
        check("mem_addr", 32'(mem_addr), 32'(q_addr[0]));
        check("mem_wdata", mem_wdata, q_data[0]);
      end else begin
        check("mem_addr_idle", 32'(mem_addr), 32'h0);
        check("mem_wdata_idle", mem_wdata, 32'h0);
      end
      check("req_ready", 32'(req_ready), 32'((q_addr.size() < DEPTH) && !start));
      check("idle", 32'(idle), 32'(q_addr.size() == 0));
      check("err", 32'(err), 32'(m_err));
      check("count", 32'(count), 32'(m_count));
      if (mem_we && mem_ready) begin
        lg_addr.push_back(int'(mem_addr));
        lg_data.push_back(mem_wdata);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    int t;
    t = 0;
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_target = tgt;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", 32'(t < 50), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    base_addr = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lg_addr.delete();
    lg_data.delete();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!idle && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(t < 100), 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int i, input int a, input logic [31:0] d);
    check({name, "_present"}, 32'(lg_addr.size() > i), 32'h1);
    if (lg_addr.size() > i) begin
      check({name, "_addr"}, 32'(lg_addr[i]), 32'(a));
      check({name, "_data"}, lg_data[i], d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; req_valid = 1'b0;
    req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    check("rst_err", 32'(err), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD
    mem_ready = 1'b1;
    do_start(6'd0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    wait_idle();
    check_log("add", 0, 0, 32'h00221820);
    check("add_count", 32'(count), 32'h1);

    // Back-to-back LW, LUI (rs must be ignored), J
    do_start(6'd0);
    send(4'd5, 5'd0, 5'd2, 5'd0, 16'h0050, 26'h0);
    send(4'd9, 5'd7, 5'd4, 5'd0, 16'h1234, 26'h0);
    send(4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000003);
    wait_idle();
    check_log("mix_lw", 0, 0, 32'h8C020050);
    check_log("mix_lui", 1, 1, 32'h3C041234);
    check_log("mix_j", 2, 2, 32'h08000003);

    // BEQ offsets, backward and forward
    do_start(6'd5);
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'h0, 26'd5);
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'h0, 26'd8);
    wait_idle();
    check_log("beq_back", 0, 5, 32'h1022FFFF);
    check_log("beq_fwd", 1, 6, 32'h10220001);

    // Back-pressure: DEPTH+2 ADDIs with memory stalled
    mem_ready = 1'b0;
    do_start(6'h10);
    fork
      begin
        for (int i = 0; i < DEPTH + 2; i++) send(4'd8, 5'd0, 5'd5, 5'd0, 16'(i), 26'h0);
      end
      begin
        repeat (8) @(negedge clk);
        check("bp_full_ready", 32'(req_ready), 32'h0);
        check("bp_no_write", 32'(count), 32'h0);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
      end
    join
    wait_idle();
    for (int i = 0; i < DEPTH + 2; i++) check_log("bp", i, 16 + i, 32'h20050000 | 32'(i));
    check("bp_count", 32'(count), 32'(DEPTH + 2));

    // Illegal kind
    do_start(6'h20);
    send(4'd13, 5'd1, 5'd1, 5'd1, 16'h1, 26'h0);
    @(negedge clk);
    check("ill_err", 32'(err), 32'h1);
    check("ill_idle", 32'(idle), 32'h1);
    @(posedge clk);
    #1;
    send(4'd10, 5'd3, 5'd4, 5'd0, 16'hABCD, 26'h0);
    wait_idle();
    check("ill_nwrites", 32'(lg_addr.size()), 32'h1);
    check_log("ill_ori", 0, 32, 32'h3464ABCD);
    do_start(6'd0);
    @(negedge clk);
    check("ill_err_cleared", 32'(err), 32'h0);
    @(posedge clk);
    #1;

    // Wrap, with an ignored start while not idle
    mem_ready = 1'b0;
    do_start(6'd63);
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    base_addr = 6'd40;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    mem_ready = 1'b1;
    wait_idle();
    check_log("wrap_sub", 0, 63, 32'h00221822);
    check_log("wrap_and", 1, 0, 32'h00221824);
    check("wrap_count", 32'(count), 32'h2);

    // Asynchronous reset with two words queued
    mem_ready = 1'b0;
    send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_we", 32'(mem_we), 32'h0);
    check("arst_idle", 32'(idle), 32'h1);
    check("arst_mem_wdata", mem_wdata, 32'h0);
    check("arst_count", 32'(count), 32'h0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    lg_addr.delete();
    lg_data.delete();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    wait_idle();
    check_log("post_rst", 0, 0, 32'h00221820);
    check("post_rst_count", 32'(count), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
